// File: rtl/sd_sector_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sd_sector_writer: streams a CPU-filled sector buffer to sd_controller       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sd_sector_writer #(
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        buf_we,
  input  logic [8:0]  buf_waddr,
  input  logic [7:0]  buf_wdata,
  input  logic        addr_we,
  input  logic [31:0] addr_wdata,
  input  logic        start,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_address,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [9:0]  byte_count
);

  localparam int              AW       = $clog2(SECTOR_BYTES);
  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0]      LAST_IDX = 10'(SECTOR_BYTES - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_ARMED    = 3'd2,
    S_STREAM   = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sd_wr_q, sd_wr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [9:0]      byte_count_q, byte_count_d;
  logic [31:0]     addr_q, addr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rdy_q;
  logic [7:0]      rd_data_q;
  logic [7:0]      mem_q [SECTOR_BYTES];

  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            nb_edge;

  // Buffer RAM: no reset so it maps onto block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (buf_we && !busy_q) begin
      mem_q[buf_waddr[AW-1:0]] <= buf_wdata;
    end
  end

  // Read port stays frozen outside an active transfer so sd_din holds its last byte.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      rd_data_q <= 8'h00;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  always_comb begin
    state_d      = state_q;
    sd_wr_d      = sd_wr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    byte_count_d = byte_count_q;
    addr_d       = addr_q;
    tmo_d        = tmo_q;
    rd_en        = 1'b0;
    rd_addr      = '0;
    nb_edge      = (state_q == S_STREAM) && sd_ready_for_next_byte && !rdy_q;

    if (addr_we && !busy_q) begin
      addr_d = addr_wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          byte_count_d = 10'd0;
          state_d      = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        rd_en = 1'b1;
        if (sd_ready) begin
          sd_wr_d = 1'b1;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        rd_en = 1'b1;
        if (!sd_ready) begin
          sd_wr_d = 1'b0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        rd_en   = 1'b1;
        rd_addr = byte_count_q[AW-1:0];
        if (nb_edge) begin
          byte_count_d = byte_count_q + 10'd1;
          if (byte_count_q == LAST_IDX) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        if (sd_ready) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog: any progress (state change or consumed byte) restarts the window.
    if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if ((state_d != state_q) || nb_edge) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
      sd_wr_d = 1'b0;
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q      <= S_IDLE;
      sd_wr_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      byte_count_q <= 10'd0;
      addr_q       <= 32'd0;
      tmo_q        <= '0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sd_wr_q      <= sd_wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      byte_count_q <= byte_count_d;
      addr_q       <= addr_d;
      tmo_q        <= tmo_d;
      rdy_q        <= sd_ready_for_next_byte;
    end
  end

  assign sd_wr      = sd_wr_q;
  assign sd_din     = rd_data_q;
  assign sd_address = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sd_sector_writer: directed self-checking bench for sd_sector_writer      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_sd_sector_writer;

  localparam int TMO = 100;

  logic        clk;
  logic        rst_n;
  logic        buf_we;
  logic [8:0]  buf_waddr;
  logic [7:0]  buf_wdata;
  logic        addr_we;
  logic [31:0] addr_wdata;
  logic        start;
  logic        sd_ready;
  logic        sd_rfnb;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_address;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  byte_count;

  int          n_checks;
  int          n_fail;
  logic [7:0]  exp_mem [512];

  sd_sector_writer #(
    .SECTOR_BYTES   (512),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50               (clk),
    .KEY0                   (rst_n),
    .buf_we                 (buf_we),
    .buf_waddr              (buf_waddr),
    .buf_wdata              (buf_wdata),
    .addr_we                (addr_we),
    .addr_wdata             (addr_wdata),
    .start                  (start),
    .sd_ready               (sd_ready),
    .sd_ready_for_next_byte (sd_rfnb),
    .sd_wr                  (sd_wr),
    .sd_din                 (sd_din),
    .sd_address             (sd_address),
    .busy                   (busy),
    .done                   (done),
    .error                  (error),
    .byte_count             (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: inputs change only on the falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    addr_we    = 1'b1;
    addr_wdata = a;
    @(negedge clk);
    addr_we    = 1'b0;
  endtask

  task automatic begin_xfer();
    sd_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    sd_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic nb_pulse(input int hold);
    sd_rfnb = 1'b1;
    repeat (hold) @(negedge clk);
    sd_rfnb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sd_wr, busy, done, error} !== 4'b0000 || sd_din !== 8'h00 ||
        sd_address !== 32'h0 || byte_count !== 10'd0) begin
      n_fail++;
      $display("FAIL reset: wr=%b busy=%b done=%b err=%b din=%h addr=%h cnt=%0d, all must be 0",
               sd_wr, busy, done, error, sd_din, sd_address, byte_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_buffer();
    for (int i = 0; i < 512; i++) begin
      buf_we    = 1'b1;
      buf_waddr = 9'(i);
      buf_wdata = 8'(i);
      exp_mem[i] = 8'(i);
      @(negedge clk);
    end
    buf_we = 1'b0;
  endtask

  task automatic test_basic();
    set_addr(32'h0000_0010);
    sd_ready = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sd_wr !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_wait_rdy: wr=%b busy=%b, required wr=0 busy=1", sd_wr, busy);
    end
    sd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sd_wr !== 1'b1 || sd_din !== exp_mem[0]) begin
      n_fail++;
      $display("FAIL basic_wr_rise: wr=%b din=%h, required wr=1 din=%h", sd_wr, sd_din, exp_mem[0]);
    end
    sd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sd_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wr_fall: wr=%b, required 0", sd_wr);
    end
    for (int k = 0; k < 512; k++) begin
      n_checks++;
      if (sd_din !== exp_mem[k]) begin
        n_fail++;
        $display("FAIL basic_byte[%0d]: din=%h, required %h", k, sd_din, exp_mem[k]);
      end
      nb_pulse(1);
    end
    n_checks++;
    if (byte_count !== 10'd512 || busy !== 1'b1 || done !== 1'b0 || sd_din !== 8'hFF) begin
      n_fail++;
      $display("FAIL basic_finish_wait: cnt=%0d busy=%b done=%b din=%h, required 512 1 0 ff",
               byte_count, busy, done, sd_din);
    end
    sd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || byte_count !== 10'd512 ||
        sd_address !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b err=%b cnt=%0d addr=%h, required 1 0 0 512 00000010",
               done, busy, error, byte_count, sd_address);
    end
  endtask

  task automatic test_handshake();
    begin_xfer();
    for (int k = 0; k < 512; k++) begin
      n_checks++;
      if (sd_din !== exp_mem[k]) begin
        n_fail++;
        $display("FAIL hs_byte[%0d]: din=%h, required %h", k, sd_din, exp_mem[k]);
      end
      nb_pulse(40);
      n_checks++;
      if (byte_count !== 10'(k + 1)) begin
        n_fail++;
        $display("FAIL hs_count[%0d]: cnt=%0d, required %0d", k, byte_count, k + 1);
      end
    end
    sd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || byte_count !== 10'd512) begin
      n_fail++;
      $display("FAIL hs_done: done=%b busy=%b cnt=%0d, required 1 0 512", done, busy, byte_count);
    end
  endtask

  task automatic test_busy_lockout();
    set_addr(32'h0000_0010);
    begin_xfer();
    for (int k = 0; k < 10; k++) nb_pulse(1);
    start      = 1'b1;
    buf_we     = 1'b1;
    buf_waddr  = 9'd0;
    buf_wdata  = 8'hAA;
    addr_we    = 1'b1;
    addr_wdata = 32'h0000_0005;
    @(negedge clk);
    start   = 1'b0;
    buf_we  = 1'b0;
    addr_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (byte_count !== 10'd10 || busy !== 1'b1 || sd_address !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL lockout_mid: cnt=%0d busy=%b addr=%h, required 10 1 00000010",
               byte_count, busy, sd_address);
    end
    for (int k = 10; k < 512; k++) begin
      n_checks++;
      if (sd_din !== exp_mem[k]) begin
        n_fail++;
        $display("FAIL lockout_byte[%0d]: din=%h, required %h", k, sd_din, exp_mem[k]);
      end
      nb_pulse(1);
    end
    sd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || sd_address !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL lockout_end: done=%b addr=%h, required 1 00000010", done, sd_address);
    end
    // Peek buffer[0] through a fresh request, then let the watchdog abort it in ARMED.
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (sd_wr !== 1'b1 || sd_din !== exp_mem[0]) begin
      n_fail++;
      $display("FAIL lockout_buf0: wr=%b din=%h, required 1 %h", sd_wr, sd_din, exp_mem[0]);
    end
    repeat (TMO + 5) @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || sd_wr !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL armed_timeout: err=%b busy=%b wr=%b done=%b, required 1 0 0 0",
               error, busy, sd_wr, done);
    end
  endtask

  task automatic test_timeout();
    sd_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: err=%b busy=%b done=%b at cycle %0d, required 0 1 0",
               error, busy, done, TMO - 1);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || sd_wr !== 1'b0 || done !== 1'b0 || byte_count !== 10'd0) begin
      n_fail++;
      $display("FAIL timeout: err=%b busy=%b wr=%b done=%b cnt=%0d at cycle %0d, required 1 0 0 0 0",
               error, busy, sd_wr, done, byte_count, TMO);
    end
  endtask

  task automatic test_same_cycle();
    sd_ready  = 1'b1;
    buf_we    = 1'b1;
    buf_waddr = 9'd0;
    buf_wdata = 8'h5A;
    start     = 1'b1;
    exp_mem[0] = 8'h5A;
    @(negedge clk);
    buf_we = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sd_wr !== 1'b1 || sd_din !== 8'h5A || error !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle: wr=%b din=%h err=%b, required 1 5a 0", sd_wr, sd_din, error);
    end
    repeat (TMO + 5) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    begin_xfer();
    for (int k = 0; k < 37; k++) nb_pulse(1);
    n_checks++;
    if (byte_count !== 10'd37 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_progress: cnt=%0d busy=%b, required 37 1", byte_count, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sd_wr, busy, done, error} !== 4'b0000 || sd_din !== 8'h00 ||
        sd_address !== 32'h0 || byte_count !== 10'd0) begin
      n_fail++;
      $display("FAIL midop_reset: wr=%b busy=%b done=%b err=%b din=%h addr=%h cnt=%0d, all must be 0",
               sd_wr, busy, done, error, sd_din, sd_address, byte_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sd_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (sd_wr !== 1'b1 || sd_din !== exp_mem[0] || byte_count !== 10'd0) begin
      n_fail++;
      $display("FAIL midop_restart: wr=%b din=%h cnt=%0d, required 1 %h 0",
               sd_wr, sd_din, byte_count, exp_mem[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    buf_we     = 1'b0;
    buf_waddr  = 9'd0;
    buf_wdata  = 8'd0;
    addr_we    = 1'b0;
    addr_wdata = 32'd0;
    start      = 1'b0;
    sd_ready   = 1'b0;
    sd_rfnb    = 1'b0;
    @(negedge clk);
    test_reset();
    fill_buffer();
    test_basic();
    test_handshake();
    test_busy_lockout();
    test_timeout();
    test_same_cycle();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
